pipeline_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB). It keeps a three-slot scoreboard of in-flight destination registers in EX, MEM and WB. From that scoreboard and the ID-stage decode it drives:
- stage enables and bubble/flush controls;
- operand-forwarding selects for ID;
- a freeze on data-memory wait states, plus a saturating stall-cycle counter.

---
 rtl/pipeline_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).
// Tracks the destination registers of the instructions sitting in EX, MEM
// and WB in a three-slot scoreboard. From the scoreboard and the ID decode
// it produces the stage enables, bubble/flush controls, operand-forwarding
// selects, a freeze while data memory is waiting, and a saturating count of
// cycles in which the PC did not advance.
//
// Build option:
//   PIPE_HAZARD_FWD_EN  defined   -> forwarding from EX/MEM/WB. The only stall
//                                    is a 1-cycle load-use stall.
//                       undefined -> full interlock. ID waits until no slot
//                                    writes one of its sources. The forwarding
//                                    selects are held at 0.
//
// Ports:
//   clk, reset         core clock; synchronous active-high reset
//   id_valid           ID holds a real instruction
//   id_rs1_addr/_re    ID source 1 address / read enable
//   id_rs2_addr/_re    ID source 2 address / read enable
//   id_rd_addr/_we     ID destination address / write enable
//   id_is_load         ID instruction is a load (result late, from MEM)
//   id_is_mem          ID instruction accesses data memory
//   id_br              ID branch taken
//   mem_ready          data memory completes its access this cycle
//   pc_en              PC update enable
//   if_id_en           IF/ID register enable
//   flush_if_id        IF/ID register loads a NOP
//   id_ex_bubble       ID/EX register loads a NOP
//   pipe_en            ID/EX, EX/MEM, MEM/WB register enable
//   fwd_sel_rs1/_rs2   0 regfile, 1 EX result, 2 MEM result/load data, 3 WB
//   state              0 RUN, 1 HAZ_STALL, 2 MEM_WAIT (previous-cycle view)
//   stall_cycles       saturating count of cycles with pc_en=0
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_re,
    input  logic             id_rs2_re,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             id_is_mem,
    input  logic             id_br,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             flush_if_id,
    output logic             id_ex_bubble,
    output logic             pipe_en,
    output logic [1:0]       fwd_sel_rs1,
    output logic [1:0]       fwd_sel_rs2,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] rd;
        logic       ld;
        logic       mem;
    } slot_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HAZ_STALL = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t  ex_q, mem_q, wb_q;
    slot_t  issue;
    state_t state_q, state_d;

    logic ex_rs1, ex_rs2, mem_rs1, mem_rs2, wb_rs1, wb_rs2;
    logic freeze;
    logic haz_raw;
    logic haz;
    logic [1:0] fwd1_raw, fwd2_raw;

    // Slot writes a register that ID actually reads. x0 never creates a
    // dependence because it is hard-wired to zero.
    function automatic logic slot_match(input slot_t s, input logic [4:0] src,
                                        input logic re);
        return s.v && s.we && (s.rd != 5'd0) && (s.rd == src) && re;
    endfunction

    assign ex_rs1  = slot_match(ex_q,  id_rs1_addr, id_rs1_re);
    assign ex_rs2  = slot_match(ex_q,  id_rs2_addr, id_rs2_re);
    assign mem_rs1 = slot_match(mem_q, id_rs1_addr, id_rs1_re);
    assign mem_rs2 = slot_match(mem_q, id_rs2_addr, id_rs2_re);
    assign wb_rs1  = slot_match(wb_q,  id_rs1_addr, id_rs1_re);
    assign wb_rs2  = slot_match(wb_q,  id_rs2_addr, id_rs2_re);

    assign freeze = mem_q.v & mem_q.mem & ~mem_ready;

`ifdef PIPE_HAZARD_FWD_EN
    // A load in EX has no data yet, so it forces a stall instead of a
    // forward; the dependent instruction picks the value from MEM next cycle.
    assign haz_raw = (ex_rs1 | ex_rs2) & ex_q.ld;

    // Youngest producer wins.
    always_comb begin
        fwd1_raw = 2'd0;
        if (ex_rs1) begin
            fwd1_raw = ex_q.ld ? 2'd0 : 2'd1;
        end else if (mem_rs1) begin
            fwd1_raw = 2'd2;
        end else if (wb_rs1) begin
            fwd1_raw = 2'd3;
        end
    end

    always_comb begin
        fwd2_raw = 2'd0;
        if (ex_rs2) begin
            fwd2_raw = ex_q.ld ? 2'd0 : 2'd1;
        end else if (mem_rs2) begin
            fwd2_raw = 2'd2;
        end else if (wb_rs2) begin
            fwd2_raw = 2'd3;
        end
    end
`else
    assign haz_raw  = ex_rs1 | ex_rs2 | mem_rs1 | mem_rs2 | wb_rs1 | wb_rs2;
    assign fwd1_raw = 2'd0;
    assign fwd2_raw = 2'd0;
`endif

    assign haz = haz_raw & id_valid;

    assign issue = '{v:   id_valid,
                     we:  id_rd_we,
                     rd:  id_rd_addr,
                     ld:  id_is_load,
                     mem: id_is_mem};

    // Scoreboard follows the pipeline registers: hold on freeze, shift a
    // bubble into EX on a hazard, otherwise shift the ID instruction in.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= haz ? slot_t'('0) : issue;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Controls depend on the current conditions only; the state register is
    // a record of what the previous cycle did.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        pipe_en      = 1'b0;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        fwd_sel_rs1  = 2'd0;
        fwd_sel_rs2  = 2'd0;
        state_d      = state_q;

        if (!reset) begin
            fwd_sel_rs1 = fwd1_raw;
            fwd_sel_rs2 = fwd2_raw;
            if (freeze) begin
                // Whole pipe holds; a pending hazard or branch stays in ID
                // and is looked at again once memory answers.
            end else if (haz) begin
                pipe_en      = 1'b1;
                id_ex_bubble = 1'b1;
            end else begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                pipe_en     = 1'b1;
                flush_if_id = id_br & id_valid;
            end
        end

        case (state_q)
            RUN: begin
                if (freeze)   state_d = MEM_WAIT;
                else if (haz) state_d = HAZ_STALL;
                else          state_d = RUN;
            end
            HAZ_STALL: begin
                if (freeze)   state_d = MEM_WAIT;
                else if (haz) state_d = HAZ_STALL;
                else          state_d = RUN;
            end
            MEM_WAIT: begin
                if (!freeze) state_d = haz ? HAZ_STALL : RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

    assign state = state_q;

    // WB only needs rd/we for dependence checks; its kind bits ride along.
    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_q.ld, wb_q.mem};

endmodule
